// File: rtl/button_gesture.sv
// Gesture classifier for a debounced button: click, double-click, long-press and auto-repeat.
// The auto-repeat event is exposed as repeat_pulse because "repeat" is a reserved word.
module button_gesture #(
   parameter int LONG_CYCLES   = 8,
   parameter int GAP_CYCLES    = 4,
   parameter int REPEAT_CYCLES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic in,
   output logic click,
   output logic double_click,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      else       m = m;
      if (c > m) m = c;
      else       m = m;
      return m;
   endfunction

   localparam int CNT_MAX = max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRESS1 = 3'd1,
      ST_GAP    = 3'd2,
      ST_PRESS2 = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             in_q_r;
   logic             click_s, double_s, long_s, repeat_s, held_s;

   // State, counter and previous-sample registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         in_q_r  <= 1'b1;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         in_q_r  <= in;
      end
   end

   // Next-state, counter and pulse decode
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      click_s  = 1'b0;
      double_s = 1'b0;
      long_s   = 1'b0;
      repeat_s = 1'b0;
      if (!en) begin
         state_s = ST_IDLE;
         cnt_s   = CNT_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in && !in_q_r) begin
                  state_s = ST_PRESS1;
                  cnt_s   = CNT_ZERO;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_PRESS1: begin
               if (!in) begin
                  state_s = ST_GAP;
                  cnt_s   = CNT_ZERO;
               end else if (cnt_r == LONG_LAST) begin
                  state_s = ST_HOLD;
                  cnt_s   = CNT_ZERO;
                  long_s  = 1'b1;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            // A press on the final gap cycle still counts as the second press
            ST_GAP: begin
               if (in) begin
                  state_s  = ST_PRESS2;
                  cnt_s    = CNT_ZERO;
                  double_s = 1'b1;
               end else if (cnt_r == GAP_LAST) begin
                  state_s = ST_IDLE;
                  cnt_s   = CNT_ZERO;
                  click_s = 1'b1;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            ST_PRESS2: begin
               if (!in) begin
                  state_s = ST_IDLE;
                  cnt_s   = CNT_ZERO;
               end else begin
                  state_s = ST_PRESS2;
               end
            end
            ST_HOLD: begin
               if (!in) begin
                  state_s = ST_IDLE;
                  cnt_s   = CNT_ZERO;
               end else if (cnt_r == REP_LAST) begin
                  cnt_s    = CNT_ZERO;
                  repeat_s = 1'b1;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
            end
         endcase
      end
      held_s = (state_s == ST_PRESS1) || (state_s == ST_PRESS2) || (state_s == ST_HOLD);
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         click        <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
         repeat_pulse <= 1'b0;
         held         <= 1'b0;
      end else begin
         click        <= click_s;
         double_click <= double_s;
         long_press   <= long_s;
         repeat_pulse <= repeat_s;
         held         <= held_s;
      end
   end

endmodule

// File: tb/tb_button_gesture.sv
// Bench for button_gesture: timestamp-based gesture model checked every cycle, plus literal timing checks.
module tb_button_gesture;

   localparam int LONG = 8;
   localparam int GAP  = 4;
   localparam int REP  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;
   logic in = 1'b0;
   logic click, double_click, long_press, repeat_pulse, held;

   button_gesture #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .REPEAT_CYCLES(REP)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in),
      .click(click), .double_click(double_click), .long_press(long_press),
      .repeat_pulse(repeat_pulse), .held(held)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk = n_chk + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a gesture is described by its press edge index e0 and release edge index er.
   typedef struct {
      bit active; bit second; bit prev;
      int e0; int er;
      bit c; bit d; bit l; bit r; bit h;
   } mdl_t;

   function automatic mdl_t model_step(input mdl_t s, input bit v_in, input bit v_en, input int n);
      mdl_t m;
      int   dt;
      m = s;
      m.c = 0; m.d = 0; m.l = 0; m.r = 0; m.h = 0;
      if (!v_en) begin
         m.active = 0;
      end else if (!m.active) begin
         if (v_in && !s.prev) begin
            m.active = 1; m.second = 0; m.e0 = n; m.er = -1; m.h = 1;
         end
      end else if (m.second) begin
         if (v_in) m.h = 1;
         else      m.active = 0;
      end else if (m.er < 0) begin
         dt = n - m.e0;
         if (!v_in) begin
            if (dt > LONG) m.active = 0;
            else           m.er = n;
         end else begin
            m.h = 1;
            if (dt == LONG) m.l = 1;
            if (dt > LONG && ((dt - LONG) % REP) == 0) m.r = 1;
         end
      end else begin
         dt = n - m.er;
         if (v_in) begin
            m.d = 1; m.h = 1; m.second = 1;
         end else if (dt == GAP) begin
            m.c = 1; m.active = 0;
         end
      end
      m.prev = v_in;
      return m;
   endfunction

   mdl_t mdl = '{active: 0, second: 0, prev: 1, e0: 0, er: -1, c: 0, d: 0, l: 0, r: 0, h: 0};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n)
         mdl <= '{active: 0, second: 0, prev: 1, e0: 0, er: -1, c: 0, d: 0, l: 0, r: 0, h: 0};
      else
         mdl <= model_step(mdl, in, en, cyc + 1);
   end

   int n_click = 0, n_double = 0, n_long = 0, n_rep = 0, n_held = 0;
   int t_click = -1, t_double = -1, t_long = -1, t_rep = -1, t_held = -1;

   // Per-cycle comparison against the model, plus pulse bookkeeping
   always @(negedge clk) begin
      chk("click", int'(click), rst_n ? int'(mdl.c) : 0);
      chk("double_click", int'(double_click), rst_n ? int'(mdl.d) : 0);
      chk("long_press", int'(long_press), rst_n ? int'(mdl.l) : 0);
      chk("repeat", int'(repeat_pulse), rst_n ? int'(mdl.r) : 0);
      chk("held", int'(held), rst_n ? int'(mdl.h) : 0);
      if (click)        begin n_click  = n_click + 1;  t_click  = cyc; end
      if (double_click) begin n_double = n_double + 1; t_double = cyc; end
      if (long_press)   begin n_long   = n_long + 1;   t_long   = cyc; end
      if (repeat_pulse) begin n_rep    = n_rep + 1;    t_rep    = cyc; end
      if (held)         begin n_held   = n_held + 1;   t_held   = cyc; end
   end

   task automatic step(input logic v_in, input logic v_en);
      in = v_in;
      en = v_en;
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input logic v_in, input int k);
      for (int i = 0; i < k; i++) step(v_in, 1'b1);
   endtask

   int b_click, b_double, b_long, b_rep, b_held;
   task automatic base();
      b_click = n_click; b_double = n_double; b_long = n_long; b_rep = n_rep; b_held = n_held;
   endtask

   int e0, er, e2;

   initial begin
      // Reset with in low, then with in held through release
      steps(1'b0, 3);
      rst_n = 1'b1;
      base();
      steps(1'b0, 3);
      rst_n = 1'b0;
      steps(1'b1, 2);
      rst_n = 1'b1;
      steps(1'b1, 5);
      chk("reset_no_held", n_held - b_held, 0);
      chk("reset_no_pulse", n_click + n_double + n_long + n_rep - b_click - b_double - b_long - b_rep, 0);
      steps(1'b0, 2);

      // Single click
      base();
      steps(1'b1, 3);
      step(1'b0, 1'b1); er = cyc;
      steps(1'b0, 6);
      chk("click_count", n_click - b_click, 1);
      chk("click_time", t_click - er, 4);
      chk("click_held_cycles", n_held - b_held, 3);
      chk("click_other", n_double + n_long + n_rep - b_double - b_long - b_rep, 0);

      // Double click after a two-sample gap
      base();
      steps(1'b1, 3);
      step(1'b0, 1'b1); er = cyc;
      step(1'b0, 1'b1);
      step(1'b1, 1'b1); e2 = cyc;
      steps(1'b1, 2);
      steps(1'b0, 6);
      chk("dbl_count", n_double - b_double, 1);
      chk("dbl_time", t_double - e2, 0);
      chk("dbl_gap", e2 - er, 2);
      chk("dbl_no_click", n_click - b_click, 0);

      // Second press exactly on the last gap sample
      base();
      steps(1'b1, 3);
      step(1'b0, 1'b1); er = cyc;
      steps(1'b0, 3);
      step(1'b1, 1'b1);
      steps(1'b0, 6);
      chk("bnd_dbl_count", n_double - b_double, 1);
      chk("bnd_dbl_time", t_double - er, 4);
      chk("bnd_no_click", n_click - b_click, 0);

      // Long hold released at E0+20
      base();
      step(1'b1, 1'b1); e0 = cyc;
      steps(1'b1, 19);
      step(1'b0, 1'b1);
      steps(1'b0, 3);
      chk("long_count", n_long - b_long, 1);
      chk("long_time", t_long - e0, 8);
      chk("rep_count", n_rep - b_rep, 3);
      chk("rep_last_time", t_rep - e0, 17);
      chk("hold_held_last", t_held - e0, 19);
      chk("hold_held_cycles", n_held - b_held, 20);
      chk("hold_no_click", n_click + n_double - b_click - b_double, 0);

      // Enable dropped mid-press, raised while still held
      base();
      step(1'b1, 1'b1);
      steps(1'b1, 4);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      steps(1'b1, 12);
      chk("en_no_long", n_long - b_long, 0);
      chk("en_no_pulse", n_click + n_double + n_rep - b_click - b_double - b_rep, 0);
      steps(1'b0, 2);
      base();
      steps(1'b1, 3);
      step(1'b0, 1'b1); er = cyc;
      steps(1'b0, 6);
      chk("en_after_click", n_click - b_click, 1);
      chk("en_after_click_time", t_click - er, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/button_gesture.md
# button_gesture

Classifies a debounced, active-high button level into single-cycle gesture events: click, double-click, long-press and auto-repeat while held. It sits directly after the debounce stage in a button path, in place of a plain edge pulse, and drives UI and control logic that needs more than one action per physical button. All timing thresholds are cycle counts set by parameters, so the block has no dependency on the clock frequency.

## Interface
- `LONG_CYCLES`, default 8: cycles the button must stay held after the press edge before `long_press` fires. Minimum 1.
- `GAP_CYCLES`, default 4: maximum released cycles between a short press and a second press for a double-click. Minimum 1.
- `REPEAT_CYCLES`, default 3: period of `repeat` pulses after `long_press`. Minimum 1.
- `clk  in  1`: single clock. All logic runs on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `en  in  1`: gesture detection enable. Low forces the FSM to IDLE synchronously.
- `in  in  1`: debounced button level, 1 = pressed. Already synchronous to `clk`.
- `click  out  1`: one-cycle pulse for a single short press.
- `double_click  out  1`: one-cycle pulse on the second press of a double-click.
- `long_press  out  1`: one-cycle pulse when the hold reaches the long threshold.
- `repeat  out  1`: one-cycle pulse every `REPEAT_CYCLES` while held after a long press.
- `held  out  1`: registered level, high while the FSM is in PRESS1, PRESS2 or HOLD.

## Operation
- Registers:
  - `in_q`, the previous sample of `in`, reset to 1.
  - State register, reset to IDLE.
  - Counter `cnt`, width `$clog2(max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)+1)`, reset to 0.
  - All outputs are registered.
- Press edge is defined as `in`=1 && `in_q`=0. Because `in_q` resets to 1, a button held through reset produces nothing until it is released and pressed again.
- IDLE:
  - Press edge -> PRESS1, `cnt`=0.
- PRESS1:
  - `in`=0 -> GAP, `cnt`=0.
  - `in`=1 and `cnt`==LONG_CYCLES-1 -> HOLD, `cnt`=0, `long_press` pulse.
  - Otherwise `cnt`++.
- GAP:
  - `in`=1 -> PRESS2 with a `double_click` pulse. This holds even when `cnt`==GAP_CYCLES-1: the press wins over the timeout.
  - `in`=0 and `cnt`==GAP_CYCLES-1 -> IDLE with a `click` pulse.
  - Otherwise `cnt`++.
- PRESS2:
  - No long-press detection.
  - `in`=0 -> IDLE.
- HOLD:
  - `in`=0 -> IDLE with no pulse. Release takes priority over a coincident repeat.
  - `in`=1 and `cnt`==REPEAT_CYCLES-1 -> `repeat` pulse, `cnt`=0.
  - Otherwise `cnt`++.
- `en`=0:
  - Next state is IDLE, `cnt`=0, and all pulse outputs and `held` are 0 on the next cycle.
  - `in_q` keeps tracking `in`.
  - A press already in progress when `en` rises is ignored until a fresh press edge.
- At most one pulse output is high in any cycle. Pulses are never longer than one cycle.
- `cnt` never exceeds the threshold of the current state, so it cannot wrap.

## Timing
- Reset (`rst_n`=0, asynchronous): IDLE, `cnt`=0, `in_q`=1, and all outputs (`click`, `double_click`, `long_press`, `repeat`, `held`) are 0.
- Reset mid-gesture aborts the gesture and emits no pulse, either during reset or after it.
- Let edge E0 be the edge that samples the press edge.
- `held`: high in the cycle after E0. Falls in the cycle after the edge that samples the release.
- `long_press`: high in the cycle after edge E0+LONG_CYCLES, provided `in`=1 was sampled at E0..E0+LONG_CYCLES.
- `repeat`: high after edges E0+LONG_CYCLES+k·REPEAT_CYCLES, for k≥1, while `in` is still sampled 1 at that edge.
- Click timing, with Er the edge sampling the release in PRESS1:
  - `click` is high after edge Er+GAP_CYCLES, provided `in`=0 was sampled at Er..Er+GAP_CYCLES.
  - `double_click` is high after the first edge in Er+1..Er+GAP_CYCLES that samples `in`=1.
- Output latency is one cycle from the deciding sample. There is no combinational path from `in` or `en` to any output.

## Test plan
Defaults for all scenarios: LONG=8, GAP=4, REPEAT=3.
- Reset with `in`=0: every output is 0 during reset and after deassertion. Then hold `in`=1 through reset release -> no output and `held`=0 until a release plus a new press.
- Press for 3 samples, then release at Er -> `click` is high for exactly one cycle after Er+4, with no other pulses.
- Press 3 samples, release 2 samples, press again -> `double_click` for one cycle after the second press edge, and `click` never fires.
- Boundary: the second press is sampled exactly at Er+4 -> `double_click`, not `click`.
- Hold from E0 with release sampled at E0+20:
  - `long_press` after E0+8.
  - `repeat` after E0+11, E0+14 and E0+17.
  - No `repeat` at E0+20, where release wins.
  - `held` falls after E0+20.
- Drop `en` to 0 at E0+5 during a press, then raise it while still held -> no `long_press` and no pulses. A later release and re-press behaves normally.
